// File: rtl/pool_window_seq.sv
// 2x2 pooling window sequencer: buffers the top row of each row pair and
// replays every 2x2 window as four consecutive words for the max_reg stage.
module pool_window_seq #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
) (
  input  logic              clk,
  input  logic              master_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              pause_inputs,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    FILL_TOP,
    BOT_EVEN,
    BOT_ODD,
    EMIT
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     col, col_nx;
  logic [RW-1:0]     row, row_nx;
  logic [1:0]        k, k_nx;
  logic [DATA_W-1:0] lbuf [IMG_W];
  logic [DATA_W-1:0] bot0, bot1;
  logic              accept;

  logic [DATA_W-1:0] data_nx;
  logic              valid_nx, first_nx, last_nx, done_nx;

  // pause_inputs is high exactly in EMIT, so this is also "not replaying".
  assign accept = in_valid & ~pause_inputs;

  // NOTE: every combinational output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    k_nx     = k;
    case (state)
      FILL_TOP: begin
        if (accept) begin
          if (col == LAST_COL) begin
            col_nx   = '0;
            row_nx   = row + RW'(1);
            state_nx = BOT_EVEN;
          end else begin
            col_nx = col + CW'(1);
          end
        end
      end
      BOT_EVEN: begin
        if (accept) begin
          col_nx   = col + CW'(1);
          state_nx = BOT_ODD;
        end
      end
      BOT_ODD: begin
        if (accept) begin
          k_nx     = 2'd0;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (k == 2'd3) begin
          k_nx = 2'd0;
          if (col != LAST_COL) begin
            col_nx   = col + CW'(1);
            state_nx = BOT_EVEN;
          end else begin
            col_nx   = '0;
            row_nx   = (row == LAST_ROW) ? '0 : row + RW'(1);
            state_nx = FILL_TOP;
          end
        end else begin
          k_nx = k + 2'd1;
        end
      end
      default: state_nx = FILL_TOP;
    endcase
  end

  // Outputs are registered from the next-state view so out_first lands in
  // the cycle right after the bottom-odd pixel is accepted.
  always_comb begin
    data_nx  = '0;
    valid_nx = (state_nx == EMIT);
    first_nx = 1'b0;
    last_nx  = 1'b0;
    done_nx  = 1'b0;
    if (valid_nx) begin
      case (k_nx)
        2'd0:    data_nx = lbuf[col - CW'(1)];
        2'd1:    data_nx = lbuf[col];
        2'd2:    data_nx = bot0;
        default: data_nx = bot1;
      endcase
      first_nx = (k_nx == 2'd0);
      last_nx  = (k_nx == 2'd3);
      done_nx  = last_nx && (col == LAST_COL) && (row == LAST_ROW);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      state        <= FILL_TOP;
      col          <= '0;
      row          <= '0;
      k            <= '0;
      bot0         <= '0;
      pause_inputs <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      col          <= col_nx;
      row          <= row_nx;
      k            <= k_nx;
      if (accept && state == BOT_EVEN) bot0 <= in_data;
      pause_inputs <= valid_nx;
      out_data     <= data_nx;
      out_valid    <= valid_nx;
      out_first    <= first_nx;
      out_last     <= last_nx;
      frame_done   <= done_nx;
    end
  end

  // NOTE: the line buffer and bot1 carry no reset; they are always written
  // before being read, so resetting them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept && state == FILL_TOP) lbuf[col] <= in_data;
    if (accept && state == BOT_ODD)  bot1      <= in_data;
  end

endmodule
